// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter guarding a single shared N-bit register written by R requesters.
// Each transaction is IDLE -> GRANT -> COMMIT: grant for two cycles, then a one-cycle ack
// that coincides with the register update. A requester that drops req while granted
// aborts without touching the register or the round-robin pointer.
//
// Ports:
//   clk      - single clock, all state updates on posedge
//   reset_n  - synchronous active-low reset
//   req      - per-requester level write request, held until ack
//   wdata    - packed write data, requester i owns bits [i*N +: N]
//   grant    - registered one-hot grant, zero when idle
//   ack      - registered one-hot completion pulse (one cycle)
//   reg_q    - shared register contents
//   busy     - high whenever the FSM is not IDLE
module reg_share_arbiter #(
   parameter int unsigned N = 8,
   parameter int unsigned R = 4
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic [R-1:0]   req,
   input  logic [R*N-1:0] wdata,
   output logic [R-1:0]   grant,
   output logic [R-1:0]   ack,
   output logic [N-1:0]   reg_q,
   output logic           busy
);

   localparam int unsigned IW = $clog2(R);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_COMMIT = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [R-1:0]   grant_q, grant_d;
   logic [R-1:0]   ack_q, ack_d;
   logic [N-1:0]   data_q, data_d;
   logic [IW-1:0]  last_q, last_d;
   logic [IW-1:0]  winner_q, winner_d;
   logic           busy_q, busy_d;

   logic           rr_found;
   logic [IW-1:0]  rr_idx;
   logic [N-1:0]   win_data;

   // Round-robin search starting just after the last committed requester, with wrap.
   always_comb begin : rr_search
      int unsigned idx;
      rr_found = 1'b0;
      rr_idx   = '0;
      idx      = 0;
      for (int unsigned k = 1; k <= R; k++) begin
         idx = 32'(last_q) + k;
         if (idx >= R) idx = idx - R;
         if (!rr_found && req[IW'(idx)]) begin
            rr_found = 1'b1;
            rr_idx   = IW'(idx);
         end
      end
   end

   // Write-data slice of the current winner.
   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < R; i++) begin
         if (winner_q == IW'(i)) win_data = wdata[i*N +: N];
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ack_d    = '0;
      data_d   = data_q;
      last_d   = last_q;
      winner_d = winner_q;

      case (state_q)
         S_IDLE: begin
            grant_d = '0;
            if (rr_found) begin
               winner_d = rr_idx;
               grant_d  = R'(1) << rr_idx;
               state_d  = S_GRANT;
            end
         end
         S_GRANT: begin
            if (req[winner_q]) begin
               data_d  = win_data;
               ack_d   = grant_q;
               last_d  = winner_q;
               state_d = S_COMMIT;
            end else begin
               // Requester withdrew: abandon without side effects.
               grant_d = '0;
               state_d = S_IDLE;
            end
         end
         S_COMMIT: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
         default: begin
            grant_d = '0;
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State register; reset leaves requester 0 with top priority.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         grant_q  <= '0;
         ack_q    <= '0;
         data_q   <= '0;
         last_q   <= IW'(R - 1);
         winner_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ack_q    <= ack_d;
         data_q   <= data_d;
         last_q   <= last_d;
         winner_q <= winner_d;
         busy_q   <= busy_d;
      end
   end

   assign grant = grant_q;
   assign ack   = ack_q;
   assign reg_q = data_q;
   assign busy  = busy_q;

endmodule
